mask_bbox_extractor: RTL and testbench

Consumer of the 1-bit hand-segmentation mask stream produced by the skin/background decider. It tracks raster position over a 160x120 frame and accumulates the object pixel count and bounding box. At end of frame it presents one result record to the downstream gesture classifier over a valid/ready handshake. Accumulation of the next frame proceeds while a result is waiting to be accepted.

---
 rtl/mask_bbox_extractor.sv | 164 ++++++++++++++++
 tb/tb_mask_bbox_extractor.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mask_bbox_extractor.sv
// Accumulates object pixel count and bounding box of a 1-bit mask over one
// raster frame, then presents a registered result record over valid/ready.
module mask_bbox_extractor #(
  parameter int IMG_W      = 160,
  parameter int IMG_H      = 120,
  parameter int MIN_PIXELS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_valid,
  input  logic        sof,
  input  logic        object_image,
  output logic        result_valid,
  input  logic        result_ready,
  output logic [14:0] area,
  output logic        found,
  output logic [7:0]  x_min,
  output logic [7:0]  x_max,
  output logic [6:0]  y_min,
  output logic [6:0]  y_max,
  output logic        overrun
);

  localparam logic [7:0]  X_LAST   = 8'(IMG_W - 1);
  localparam logic [6:0]  Y_LAST   = 7'(IMG_H - 1);
  localparam logic [14:0] MIN_AREA = 15'(MIN_PIXELS);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t      state_q, state_d;
  logic [7:0]  x_q, x_d;
  logic [6:0]  y_q, y_d;
  logic [14:0] acc_area_q, acc_area_d;
  logic [7:0]  acc_xmin_q, acc_xmin_d, acc_xmax_q, acc_xmax_d;
  logic [6:0]  acc_ymin_q, acc_ymin_d, acc_ymax_q, acc_ymax_d;
  logic        rv_q, rv_d, found_q, found_d, ovr_q, ovr_d;
  logic [14:0] area_q, area_d;
  logic [7:0]  xmin_q, xmin_d, xmax_q, xmax_d;
  logic [6:0]  ymin_q, ymin_d, ymax_q, ymax_d;

  // A sof beat is pixel (0,0) of a fresh frame, whatever state we are in.
  logic        start, take, last, nxt_found;
  logic [7:0]  px, base_xmin, base_xmax, nxt_xmin, nxt_xmax;
  logic [6:0]  py, base_ymin, base_ymax, nxt_ymin, nxt_ymax;
  logic [14:0] base_area, nxt_area;

  assign start     = pix_valid && sof;
  assign take      = pix_valid && (sof || (state_q == SCAN));
  assign px        = start ? 8'd0 : x_q;
  assign py        = start ? 7'd0 : y_q;
  assign base_area = start ? 15'd0  : acc_area_q;
  assign base_xmin = start ? X_LAST : acc_xmin_q;
  assign base_xmax = start ? 8'd0   : acc_xmax_q;
  assign base_ymin = start ? Y_LAST : acc_ymin_q;
  assign base_ymax = start ? 7'd0   : acc_ymax_q;

  assign nxt_area  = base_area + {14'd0, object_image};
  assign nxt_xmin  = (object_image && (px < base_xmin)) ? px : base_xmin;
  assign nxt_xmax  = (object_image && (px > base_xmax)) ? px : base_xmax;
  assign nxt_ymin  = (object_image && (py < base_ymin)) ? py : base_ymin;
  assign nxt_ymax  = (object_image && (py > base_ymax)) ? py : base_ymax;
  assign nxt_found = (nxt_area >= MIN_AREA);
  assign last      = take && (px == X_LAST) && (py == Y_LAST);

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    acc_area_d = acc_area_q;
    acc_xmin_d = acc_xmin_q;
    acc_xmax_d = acc_xmax_q;
    acc_ymin_d = acc_ymin_q;
    acc_ymax_d = acc_ymax_q;
    rv_d       = rv_q && !result_ready;
    ovr_d      = ovr_q;
    area_d     = area_q;
    found_d    = found_q;
    xmin_d     = xmin_q;
    xmax_d     = xmax_q;
    ymin_d     = ymin_q;
    ymax_d     = ymax_q;
    if (last) begin
      state_d    = IDLE;
      x_d        = 8'd0;
      y_d        = 7'd0;
      acc_area_d = 15'd0;
      acc_xmin_d = X_LAST;
      acc_xmax_d = 8'd0;
      acc_ymin_d = Y_LAST;
      acc_ymax_d = 7'd0;
      area_d     = nxt_area;
      found_d    = nxt_found;
      xmin_d     = nxt_found ? nxt_xmin : 8'd0;
      xmax_d     = nxt_found ? nxt_xmax : 8'd0;
      ymin_d     = nxt_found ? nxt_ymin : 7'd0;
      ymax_d     = nxt_found ? nxt_ymax : 7'd0;
      rv_d       = 1'b1;
      // Overwriting a record the consumer has not taken is flagged for good.
      ovr_d      = ovr_q || (rv_q && !result_ready);
    end else if (take) begin
      state_d    = SCAN;
      acc_area_d = nxt_area;
      acc_xmin_d = nxt_xmin;
      acc_xmax_d = nxt_xmax;
      acc_ymin_d = nxt_ymin;
      acc_ymax_d = nxt_ymax;
      if (px == X_LAST) begin
        x_d = 8'd0;
        y_d = py + 7'd1;
      end else begin
        x_d = px + 8'd1;
        y_d = py;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      x_q        <= 8'd0;
      y_q        <= 7'd0;
      acc_area_q <= 15'd0;
      acc_xmin_q <= X_LAST;
      acc_xmax_q <= 8'd0;
      acc_ymin_q <= Y_LAST;
      acc_ymax_q <= 7'd0;
      rv_q       <= 1'b0;
      ovr_q      <= 1'b0;
      area_q     <= 15'd0;
      found_q    <= 1'b0;
      xmin_q     <= 8'd0;
      xmax_q     <= 8'd0;
      ymin_q     <= 7'd0;
      ymax_q     <= 7'd0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      acc_area_q <= acc_area_d;
      acc_xmin_q <= acc_xmin_d;
      acc_xmax_q <= acc_xmax_d;
      acc_ymin_q <= acc_ymin_d;
      acc_ymax_q <= acc_ymax_d;
      rv_q       <= rv_d;
      ovr_q      <= ovr_d;
      area_q     <= area_d;
      found_q    <= found_d;
      xmin_q     <= xmin_d;
      xmax_q     <= xmax_d;
      ymin_q     <= ymin_d;
      ymax_q     <= ymax_d;
    end
  end

  assign result_valid = rv_q;
  assign overrun      = ovr_q;
  assign area         = area_q;
  assign found        = found_q;
  assign x_min        = xmin_q;
  assign x_max        = xmax_q;
  assign y_min        = ymin_q;
  assign y_max        = ymax_q;

endmodule

// File: tb/tb_mask_bbox_extractor.sv
// Directed bench for mask_bbox_extractor on a reduced 80x60 frame so the whole
// run stays short; every shape used fits inside that frame.
`timescale 1ns/1ps
module tb_mask_bbox_extractor;

  localparam int W = 80;
  localparam int H = 60;
  localparam int N = W * H;

  localparam int K_EMPTY  = 0;
  localparam int K_RECT   = 1;
  localparam int K_ISO    = 2;
  localparam int K_SINGLE = 3;
  localparam int K_BOX2   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_valid = 1'b0;
  logic        sof = 1'b0;
  logic        object_image = 1'b0;
  logic        result_ready = 1'b1;
  logic        result_valid;
  logic [14:0] area;
  logic        found;
  logic [7:0]  x_min, x_max;
  logic [6:0]  y_min, y_max;
  logic        overrun;

  int errors = 0;
  int nchecks = 0;
  int rv_before;
  int area_before;

  mask_bbox_extractor #(.IMG_W(W), .IMG_H(H), .MIN_PIXELS(16)) dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .sof(sof),
    .object_image(object_image), .result_valid(result_valid),
    .result_ready(result_ready), .area(area), .found(found),
    .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          kind;
    bit          gaps;
    logic [14:0] a;
    logic        f;
    logic [7:0]  xmn, xmx;
    logic [6:0]  ymn, ymx;
  } vec_t;

  vec_t vecs[6];

  function automatic bit obj(int k, int x, int y);
    bit r = 1'b0;
    case (k)
      K_RECT:   r = (x >= 40 && x <= 59 && y >= 30 && y <= 49);
      K_ISO:    for (int i = 0; i < 10; i++) if (x == i * 7 && y == i * 5) r = 1'b1;
      K_SINGLE: r = (x == W - 1 && y == H - 1);
      K_BOX2:   r = (x >= 10 && x <= 19 && y >= 5 && y <= 14);
      default:  r = 1'b0;
    endcase
    return r;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    nchecks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_rec(input string nm, input int a, input int f,
                           input int xmn, input int xmx, input int ymn, input int ymx);
    check({nm, ".valid"}, int'(result_valid), 1);
    check({nm, ".area"},  int'(area), a);
    check({nm, ".found"}, int'(found), f);
    check({nm, ".x_min"}, int'(x_min), xmn);
    check({nm, ".x_max"}, int'(x_max), xmx);
    check({nm, ".y_min"}, int'(y_min), ymn);
    check({nm, ".y_max"}, int'(y_max), ymx);
  endtask

  // Drives npix pixels of a frame of the given shape. With first_now the first
  // pixel goes out at the current negedge (back-to-back frames).
  task automatic send_frame(input int k, input bit gaps, input bit first_now,
                            input bit ready_at_last, input int npix, input bit sof_en);
    for (int idx = 0; idx < npix; idx++) begin
      if (!(first_now && idx == 0)) begin
        @(negedge clk);
        if (gaps) begin
          while ($urandom_range(0, 99) < 30) begin
            pix_valid = 1'b0;
            sof = 1'($urandom_range(0, 1));
            object_image = 1'($urandom_range(0, 1));
            @(negedge clk);
          end
        end
      end
      if (idx == N - 1) begin
        rv_before = int'(result_valid);
        area_before = int'(area);
        if (ready_at_last) result_ready = 1'b1;
      end
      pix_valid = 1'b1;
      sof = sof_en && (idx == 0);
      object_image = obj(k, idx % W, idx / W);
    end
  endtask

  task automatic go_idle();
    @(negedge clk);
    pix_valid = 1'b0;
    sof = 1'b0;
    object_image = 1'b0;
  endtask

  initial begin
    vecs[0] = '{K_EMPTY,  1'b0, 15'd0,   1'b0, 8'd0,  8'd0,  7'd0,  7'd0};
    vecs[1] = '{K_RECT,   1'b0, 15'd400, 1'b1, 8'd40, 8'd59, 7'd30, 7'd49};
    vecs[2] = '{K_RECT,   1'b1, 15'd400, 1'b1, 8'd40, 8'd59, 7'd30, 7'd49};
    vecs[3] = '{K_ISO,    1'b0, 15'd10,  1'b0, 8'd0,  8'd0,  7'd0,  7'd0};
    vecs[4] = '{K_SINGLE, 1'b0, 15'd1,   1'b0, 8'd0,  8'd0,  7'd0,  7'd0};
    vecs[5] = '{K_BOX2,   1'b1, 15'd100, 1'b1, 8'd10, 8'd19, 7'd5,  7'd14};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst.valid", int'(result_valid), 0);
    check("rst.area", int'(area), 0);
    check("rst.found", int'(found), 0);
    check("rst.bbox", int'({x_min, x_max, y_min, y_max}), 0);
    check("rst.overrun", int'(overrun), 0);
    rst = 1'b0;

    // Table: one frame each, consumer always ready
    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].kind, vecs[i].gaps, 1'b0, 1'b0, N, 1'b1);
      check($sformatf("v%0d.pre_valid", i), rv_before, 0);
      go_idle();
      check_rec($sformatf("v%0d", i), int'(vecs[i].a), int'(vecs[i].f),
                int'(vecs[i].xmn), int'(vecs[i].xmx), int'(vecs[i].ymn), int'(vecs[i].ymx));
      check($sformatf("v%0d.overrun", i), int'(overrun), 0);
      @(negedge clk);
      check($sformatf("v%0d.drop", i), int'(result_valid), 0);
    end

    // Back-to-back frames: sof on the beat right after the final pixel
    send_frame(K_RECT, 1'b0, 1'b0, 1'b0, N, 1'b1);
    @(negedge clk);
    check_rec("b2b.first", 400, 1, 40, 59, 30, 49);
    send_frame(K_BOX2, 1'b0, 1'b1, 1'b0, N, 1'b1);
    go_idle();
    check_rec("b2b.second", 100, 1, 10, 19, 5, 14);
    @(negedge clk);
    check("b2b.drop", int'(result_valid), 0);

    // Frame completes in the same cycle as a transfer, then a true overrun
    result_ready = 1'b0;
    send_frame(K_ISO, 1'b0, 1'b0, 1'b0, N, 1'b1);
    go_idle();
    check_rec("hold.iso", 10, 0, 0, 0, 0, 0);
    send_frame(K_BOX2, 1'b0, 1'b0, 1'b1, N, 1'b1);
    check("same.pre_valid", rv_before, 1);
    check("same.held_area", area_before, 10);
    go_idle();
    result_ready = 1'b0;
    check_rec("same.box2", 100, 1, 10, 19, 5, 14);
    check("same.overrun", int'(overrun), 0);
    send_frame(K_RECT, 1'b0, 1'b0, 1'b0, N, 1'b1);
    check("ovr.held_area", area_before, 100);
    go_idle();
    check_rec("ovr.rect", 400, 1, 40, 59, 30, 49);
    check("ovr.overrun", int'(overrun), 1);
    result_ready = 1'b1;
    @(negedge clk);
    check("ovr.drop", int'(result_valid), 0);
    check("ovr.sticky", int'(overrun), 1);

    // sof mid-frame at (40,30): partial frame discarded
    send_frame(K_RECT, 1'b0, 1'b0, 1'b0, 30 * W + 40, 1'b1);
    send_frame(K_BOX2, 1'b0, 1'b0, 1'b0, N, 1'b1);
    check("restart.pre_valid", rv_before, 0);
    go_idle();
    check_rec("restart", 100, 1, 10, 19, 5, 14);
    @(negedge clk);
    check("restart.drop", int'(result_valid), 0);

    // Asynchronous reset mid-frame with a record pending
    result_ready = 1'b0;
    send_frame(K_RECT, 1'b0, 1'b0, 1'b0, N, 1'b1);
    go_idle();
    check("prerst.valid", int'(result_valid), 1);
    send_frame(K_ISO, 1'b0, 1'b0, 1'b0, 1000, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst.valid", int'(result_valid), 0);
    check("midrst.area", int'(area), 0);
    check("midrst.found", int'(found), 0);
    check("midrst.bbox", int'({x_min, x_max, y_min, y_max}), 0);
    check("midrst.overrun", int'(overrun), 0);
    @(negedge clk);
    rst = 1'b0;
    result_ready = 1'b1;
    send_frame(K_BOX2, 1'b0, 1'b0, 1'b0, N, 1'b0);
    go_idle();
    @(negedge clk);
    check("nosof.valid", int'(result_valid), 0);
    send_frame(K_BOX2, 1'b0, 1'b0, 1'b0, N, 1'b1);
    go_idle();
    check_rec("postrst", 100, 1, 10, 19, 5, 14);

    $display("Result: errors=%0d of %0d checks", errors, nchecks);
    $finish;
  end

endmodule
